// File: rtl/ms_load_resp_tracker_pkg.sv
// Shared load-op codes and slot states for the MEM-stage load response tracker.
package ms_load_resp_tracker_pkg;

   localparam logic [2:0] LDOP_B  = 3'd0;
   localparam logic [2:0] LDOP_BU = 3'd1;
   localparam logic [2:0] LDOP_H  = 3'd2;
   localparam logic [2:0] LDOP_HU = 3'd3;
   localparam logic [2:0] LDOP_W  = 3'd4;
   localparam logic [2:0] LDOP_WU = 3'd5;
   localparam logic [2:0] LDOP_D  = 3'd6;
   localparam logic [2:0] LDOP_ST = 3'd7;

   typedef enum logic [1:0] {
      SLOT_FREE = 2'd0,
      SLOT_WAIT = 2'd1,
      SLOT_DONE = 2'd2,
      SLOT_DROP = 2'd3
   } slot_st_e;

endpackage

// File: rtl/ms_load_resp_tracker_ld_align_ext.sv
// Load data alignment and sign/zero extension; purely combinational.
module ld_align_ext
   import ms_load_resp_tracker_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int LB_W   = $clog2(DATA_W / 8),
   localparam int SH_W   = LB_W + 3
) (
   input  logic [2:0]        op,
   input  logic [LB_W-1:0]   lb,
   input  logic [DATA_W-1:0] raw,
   output logic [DATA_W-1:0] ext,
   output logic              bad_op
);

   logic [SH_W-1:0] byte_sh;
   logic [SH_W-1:0] half_sh;
   logic [SH_W-1:0] word_sh;
   logic [7:0]      b;
   logic [15:0]     h;
   logic [31:0]     w;

   always_comb begin
      // Masking low lb bits gives the lane base; for a 32-bit bus the word shift is always 0.
      byte_sh = {lb, 3'b000};
      half_sh = {lb & ~LB_W'(1), 3'b000};
      word_sh = {lb & ~LB_W'(3), 3'b000};
      b       = 8'(raw >> byte_sh);
      h       = 16'(raw >> half_sh);
      w       = 32'(raw >> word_sh);
      ext     = '0;
      bad_op  = 1'b0;
      case (op)
         LDOP_B:  ext = DATA_W'($signed(b));
         LDOP_BU: ext = DATA_W'(b);
         LDOP_H:  ext = DATA_W'($signed(h));
         LDOP_HU: ext = DATA_W'(h);
         LDOP_W:  ext = DATA_W'($signed(w));
         LDOP_WU: ext = DATA_W'(w);
         LDOP_D: begin
            if (DATA_W == 64) ext = raw;
            else              bad_op = 1'b1;
         end
         default: ext = '0;
      endcase
   end

endmodule

// File: rtl/ms_load_resp_tracker.sv
// In-order tracker for outstanding data-SRAM requests: tag match, flush drop, WB stall hold.
//  state     | meaning
//  SLOT_FREE | slot unused
//  SLOT_WAIT | request issued, awaiting data_ok
//  SLOT_DONE | data returned, waiting for WS to accept
//  SLOT_DROP | request flushed, its data_ok will be swallowed
module ms_load_resp_tracker
   import ms_load_resp_tracker_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 4,
   localparam int LB_W   = $clog2(DATA_W / 8)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              iss_valid,
   input  logic [2:0]        iss_op,
   input  logic [LB_W-1:0]   iss_lb,
   output logic              iss_full,
   input  logic              flush,
   input  logic              data_ok,
   input  logic [DATA_W-1:0] rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_is_st,
   output logic              busy,
   output logic              err
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   slot_st_e          st_q   [DEPTH];
   slot_st_e          st_d   [DEPTH];
   logic [2:0]        op_q   [DEPTH];
   logic [2:0]        op_d   [DEPTH];
   logic [LB_W-1:0]   lb_q   [DEPTH];
   logic [LB_W-1:0]   lb_d   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PW-1:0]     alloc_q, alloc_d;
   logic [PW-1:0]     resp_q, resp_d;
   logic [PW-1:0]     head_q, head_d;
   logic              err_q, err_d;

   logic [IW-1:0]     alloc_idx, resp_idx, head_idx;
   logic [PW-1:0]     occ;
   logic              resp_hit, bypass, pop, iss_acc, bad_op;
   logic [DATA_W-1:0] raw_sel, ext_data;

   always_comb begin
      alloc_idx = alloc_q[IW-1:0];
      resp_idx  = resp_q[IW-1:0];
      head_idx  = head_q[IW-1:0];
      occ       = alloc_q - head_q;
      iss_full  = (occ == PW'(DEPTH));
      iss_acc   = iss_valid & ~iss_full;
      resp_hit  = data_ok & ((st_q[resp_idx] == SLOT_WAIT) | (st_q[resp_idx] == SLOT_DROP));
      bypass    = ~flush & data_ok & (st_q[head_idx] == SLOT_WAIT) & (head_q == resp_q);
      out_valid = ~flush & ((st_q[head_idx] == SLOT_DONE) | bypass);
      pop       = out_valid & out_ready;
      raw_sel   = bypass ? rdata : data_q[head_idx];
      out_data  = out_valid ? ext_data : '0;
      out_is_st = out_valid & (op_q[head_idx] == LDOP_ST);
      err       = err_q;
      busy      = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (st_q[i] != SLOT_FREE) busy = 1'b1;
      end
   end

   ld_align_ext #(.DATA_W(DATA_W)) u_align (
      .op     (op_q[head_idx]),
      .lb     (lb_q[head_idx]),
      .raw    (raw_sel),
      .ext    (ext_data),
      .bad_op (bad_op)
   );

   always_comb begin
      st_d    = st_q;
      op_d    = op_q;
      lb_d    = lb_q;
      data_d  = data_q;
      alloc_d = alloc_q;
      resp_d  = resp_q;
      head_d  = head_q;
      err_d   = err_q | (out_valid & bad_op);

      if (resp_hit) begin
         resp_d = resp_q + PW'(1);
         if (st_q[resp_idx] == SLOT_WAIT) begin
            data_d[resp_idx] = rdata;
            st_d[resp_idx]   = flush ? SLOT_FREE : SLOT_DONE;
         end else begin
            // A dropped slot is always at head, so head follows resp past it.
            st_d[resp_idx] = SLOT_FREE;
            head_d         = head_q + PW'(1);
         end
      end else if (data_ok) begin
         err_d = 1'b1;
      end

      if (pop) begin
         st_d[head_idx] = SLOT_FREE;
         head_d         = head_q + PW'(1);
      end

      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (st_q[i] == SLOT_DONE)
               st_d[i] = SLOT_FREE;
            else if (st_q[i] == SLOT_WAIT && !(resp_hit && resp_idx == IW'(i)))
               st_d[i] = SLOT_DROP;
         end
         head_d = resp_d;
      end

      if (iss_acc) begin
         st_d[alloc_idx] = flush ? SLOT_DROP : SLOT_WAIT;
         op_d[alloc_idx] = iss_op;
         lb_d[alloc_idx] = iss_lb;
         alloc_d         = alloc_q + PW'(1);
      end else if (iss_valid) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q    <= '{default: SLOT_FREE};
         op_q    <= '{default: '0};
         lb_q    <= '{default: '0};
         data_q  <= '{default: '0};
         alloc_q <= '0;
         resp_q  <= '0;
         head_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         op_q    <= op_d;
         lb_q    <= lb_d;
         data_q  <= data_d;
         alloc_q <= alloc_d;
         resp_q  <= resp_d;
         head_q  <= head_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_ms_load_resp_tracker.sv
// Directed bench for ms_load_resp_tracker: vector table for extraction, sequences for queueing/flush/reset.
module tb_ms_load_resp_tracker;
   import ms_load_resp_tracker_pkg::*;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int LB_W   = 2;
   localparam int NVEC   = 11;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              iss_valid = 1'b0;
   logic [2:0]        iss_op = 3'd0;
   logic [LB_W-1:0]   iss_lb = '0;
   logic              iss_full;
   logic              flush = 1'b0;
   logic              data_ok = 1'b0;
   logic [DATA_W-1:0] rdata = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_is_st;
   logic              busy;
   logic              err;

   always #5 clk = ~clk;

   ms_load_resp_tracker #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .iss_valid (iss_valid),
      .iss_op    (iss_op),
      .iss_lb    (iss_lb),
      .iss_full  (iss_full),
      .flush     (flush),
      .data_ok   (data_ok),
      .rdata     (rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_is_st (out_is_st),
      .busy      (busy),
      .err       (err)
   );

   typedef struct {
      logic [2:0]        op;
      logic [LB_W-1:0]   lb;
      int                lat;
      logic [DATA_W-1:0] rd;
      logic [DATA_W-1:0] exp;
      logic              exp_st;
   } vec_t;

   vec_t vt [NVEC];
   int   n_chk = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [LB_W-1:0] lb);
      iss_valid = 1'b1;
      iss_op    = op;
      iss_lb    = lb;
      cyc();
      iss_valid = 1'b0;
   endtask

   initial begin
      vt[0]  = '{LDOP_W,  2'd0, 3, 32'h8765_4321, 32'h8765_4321, 1'b0};
      vt[1]  = '{LDOP_B,  2'd3, 1, 32'h80AB_CDEF, 32'hFFFF_FF80, 1'b0};
      vt[2]  = '{LDOP_BU, 2'd3, 2, 32'h80AB_CDEF, 32'h0000_0080, 1'b0};
      vt[3]  = '{LDOP_H,  2'd2, 1, 32'h8001_1234, 32'hFFFF_8001, 1'b0};
      vt[4]  = '{LDOP_HU, 2'd2, 1, 32'h8001_1234, 32'h0000_8001, 1'b0};
      vt[5]  = '{LDOP_H,  2'd0, 2, 32'h1234_F00D, 32'hFFFF_F00D, 1'b0};
      vt[6]  = '{LDOP_B,  2'd1, 1, 32'h1234_7F56, 32'h0000_007F, 1'b0};
      vt[7]  = '{LDOP_B,  2'd2, 1, 32'h1234_5678, 32'h0000_0034, 1'b0};
      vt[8]  = '{LDOP_BU, 2'd0, 1, 32'h0000_00FF, 32'h0000_00FF, 1'b0};
      vt[9]  = '{LDOP_WU, 2'd0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vt[10] = '{LDOP_ST, 2'd0, 1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};

      // reset state
      #2;
      chk("rst_iss_full", iss_full, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err", err, 0);
      cyc();
      resetn = 1'b1;
      cyc();

      // extraction table, each access popped through the bypass path
      for (int i = 0; i < NVEC; i++) begin
         issue(vt[i].op, vt[i].lb);
         for (int k = 1; k < vt[i].lat; k++) begin
            #3 chk($sformatf("vec%0d_wait_valid", i), out_valid, 0);
            cyc();
         end
         data_ok   = 1'b1;
         rdata     = vt[i].rd;
         out_ready = 1'b1;
         #3;
         chk($sformatf("vec%0d_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
         chk($sformatf("vec%0d_is_st", i), out_is_st, vt[i].exp_st);
         cyc();
         data_ok = 1'b0;
         #3 chk($sformatf("vec%0d_busy", i), busy, 0);
      end
      chk("vec_err", err, 0);

      // fill to DEPTH with WB stalled, then drain in order
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) issue(LDOP_W, 2'd0);
      #3 chk("fill_full", iss_full, 1);
      for (int i = 0; i < DEPTH; i++) begin
         data_ok = 1'b1;
         rdata   = 32'hA000_0000 + 32'(i);
         cyc();
      end
      data_ok = 1'b0;
      #3;
      chk("fill_head_valid", out_valid, 1);
      chk("fill_head_data", out_data, 32'hA000_0000);
      chk("fill_still_full", iss_full, 1);
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         chk($sformatf("drain%0d_valid", i), out_valid, 1);
         chk($sformatf("drain%0d_data", i), out_data, 32'hA000_0000 + 32'(i));
         if (i == 0) chk("drain_pop_sees_full", iss_full, 1);
         cyc();
      end
      #3;
      chk("drain_full", iss_full, 0);
      chk("drain_busy", busy, 0);
      chk("drain_valid", out_valid, 0);

      // flush drops outstanding loads; only the later load is delivered
      issue(LDOP_W, 2'd0);
      issue(LDOP_W, 2'd0);
      flush = 1'b1;
      #3 chk("fl_cycle_valid", out_valid, 0);
      cyc();
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         data_ok = 1'b1;
         rdata   = 32'hBAD0_0000 + 32'(i);
         #3 chk($sformatf("fl_drop%0d_valid", i), out_valid, 0);
         cyc();
      end
      data_ok = 1'b0;
      #3 chk("fl_idle_busy", busy, 0);
      issue(LDOP_W, 2'd0);
      data_ok = 1'b1;
      rdata   = 32'h0000_1234;
      #3;
      chk("fl_new_valid", out_valid, 1);
      chk("fl_new_data", out_data, 32'h0000_1234);
      cyc();
      data_ok = 1'b0;

      // flush coincident with head data_ok and a new issue
      issue(LDOP_W, 2'd0);
      cyc();
      flush     = 1'b1;
      data_ok   = 1'b1;
      rdata     = 32'hCAFE_0001;
      iss_valid = 1'b1;
      iss_op    = LDOP_W;
      iss_lb    = 2'd0;
      #3 chk("flx_valid", out_valid, 0);
      cyc();
      flush     = 1'b0;
      iss_valid = 1'b0;
      data_ok   = 1'b0;
      #3 chk("flx_busy_drop", busy, 1);
      chk("flx_drop_valid_idle", out_valid, 0);
      data_ok = 1'b1;
      rdata   = 32'hCAFE_0002;
      #1 chk("flx_drop_resp_valid", out_valid, 0);
      cyc();
      data_ok = 1'b0;
      #3;
      chk("flx_busy_end", busy, 0);
      chk("flx_err", err, 0);

      // stray data_ok on an empty tracker
      data_ok = 1'b1;
      rdata   = 32'h5555_5555;
      #3 chk("stray_valid", out_valid, 0);
      cyc();
      data_ok = 1'b0;
      #3 chk("stray_err", err, 1);

      // async reset mid-flight with three entries live
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) issue(LDOP_W, 2'd0);
      data_ok = 1'b1;
      rdata   = 32'h7777_0000;
      cyc();
      data_ok = 1'b0;
      #1;
      chk("mid_valid_pre", out_valid, 1);
      chk("mid_busy_pre", busy, 1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_full", iss_full, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_err", err, 0);
      cyc();
      resetn = 1'b1;
      cyc();
      data_ok = 1'b1;
      #3 chk("post_rst_stray_valid", out_valid, 0);
      cyc();
      data_ok = 1'b0;
      #3 chk("post_rst_stray_err", err, 1);

      // D on a 32-bit bus: zero data and error
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      cyc();
      issue(LDOP_D, 2'd0);
      data_ok   = 1'b1;
      rdata     = 32'h1357_9BDF;
      out_ready = 1'b1;
      #3;
      chk("d32_valid", out_valid, 1);
      chk("d32_data", out_data, 0);
      cyc();
      data_ok = 1'b0;
      #3 chk("d32_err", err, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
